pdetect_mc: RTL and testbench

//  Multi-channel, time-multiplexed PLL phase detector. Turns raw phase

---
 rtl/pdetect_mc_pkg.sv | 15 +
 rtl/pdetect_mc_fsm.sv | 38 +++
 rtl/pdetect_mc.sv | 179 +++++++++++++++++
 tb/tb_pdetect_mc.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdetect_mc_pkg.sv
// Shared definitions for the multi-channel phase detector.
//   pd_state_t : per-channel detector state. Bit 1 marks clipping,
//                bit 0 the sign of the clip (1 = negative full scale).
//   PD_STATE_W : width of the state code as seen on state_out.
package pdetect_mc_pkg;

  localparam int PD_STATE_W = 2;

  typedef enum logic [PD_STATE_W-1:0] {
    PD_LINEAR = 2'd0,
    PD_CLIP_P = 2'd2,
    PD_CLIP_N = 2'd3
  } pd_state_t;

endpackage

// File: rtl/pdetect_mc_fsm.sv
// Next-state logic of one phase-detector channel (purely combinational).
// Ports:
//   state      : held state of the channel being processed
//   prev_quad  : quadrant (top two bits) of that channel's previous sample
//   prev_valid : previous sample exists since reset/clear
//   quad       : quadrant of the current sample
//   next       : state that applies to the current sample
//   trans_pn   : +pi -> -pi wrap seen (quadrant 01 -> 10)
//   trans_np   : -pi -> +pi wrap seen (quadrant 10 -> 01)
module pdetect_mc_fsm
  import pdetect_mc_pkg::*;
(
  input  pd_state_t  state,
  input  logic [1:0] prev_quad,
  input  logic       prev_valid,
  input  logic [1:0] quad,
  output pd_state_t  next,
  output logic       trans_pn,
  output logic       trans_np
);

  always_comb begin
    trans_pn = prev_valid && (prev_quad == 2'b01) && (quad == 2'b10);
    trans_np = prev_valid && (prev_quad == 2'b10) && (quad == 2'b01);
    next     = state;
    case (state)
      PD_LINEAR: begin
        if (trans_pn)      next = PD_CLIP_P;
        else if (trans_np) next = PD_CLIP_N;
      end
      PD_CLIP_P: if (trans_np) next = PD_LINEAR;
      PD_CLIP_N: if (trans_pn) next = PD_LINEAR;
      // Code 1 is unused; fall back to linear operation.
      default:   next = PD_LINEAR;
    endcase
  end

endmodule

// File: rtl/pdetect_mc.sv
// Multi-channel, time-multiplexed PLL phase detector.
// Converts raw wrapped phase differences into loop-filter error signals,
// saturating to a programmable full-scale level while a channel is
// cycle-slipping, and tracks per-channel lock. One clock of latency.
// Ports:
//   clk, reset  : clock; synchronous active-high reset of all channel state
//   ang_in      : raw phase difference, signed, full scale +/-pi
//   chan_in     : channel tag of ang_in (tags >= NCH are ignored)
//   strobe_in   : ang_in/chan_in valid
//   chan_clr    : one-hot per-channel soft clear
//   clip_mag    : magnitude of the clip level
//   lock_thr    : |phase| window counted as in lock
//   lock_len    : consecutive in-window samples needed for lock
//   ang_out     : error signal
//   chan_out    : channel tag of ang_out
//   strobe_out  : ang_out valid
//   state_out   : state of the channel just emitted
//   locked      : per-channel lock flags
module pdetect_mc
  import pdetect_mc_pkg::*;
#(
  parameter int DATA_W = 17,
  parameter int NCH    = 4,
  parameter int CW     = 2,
  parameter int LW     = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] ang_in,
  input  logic [CW-1:0]            chan_in,
  input  logic                     strobe_in,
  input  logic [NCH-1:0]           chan_clr,
  input  logic [DATA_W-2:0]        clip_mag,
  input  logic [DATA_W-2:0]        lock_thr,
  input  logic [LW-1:0]            lock_len,
  output logic signed [DATA_W-1:0] ang_out,
  output logic [CW-1:0]            chan_out,
  output logic                     strobe_out,
  output logic [1:0]               state_out,
  output logic [NCH-1:0]           locked
);

  localparam int           IW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW:0]  NCH_C = (CW+1)'(NCH);

  function automatic logic signed [DATA_W-1:0] err_out(
    input pd_state_t                 st,
    input logic signed [DATA_W-1:0]  a,
    input logic [DATA_W-2:0]         mag
  );
    logic signed [DATA_W-1:0] lvl;
    lvl = signed'({1'b0, mag});
    case (st)
      PD_CLIP_P: err_out = lvl;
      PD_CLIP_N: err_out = -lvl;
      default:   err_out = a;
    endcase
  endfunction

  // The most negative input wraps back onto itself, which read as unsigned
  // is 2**(DATA_W-1): larger than any lock_thr, so never in window.
  function automatic logic [DATA_W-1:0] abs_mag(input logic signed [DATA_W-1:0] a);
    logic signed [DATA_W-1:0] n;
    n = -a;
    abs_mag = a[DATA_W-1] ? n : a;
  endfunction

  function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] c);
    sat_inc = (&c) ? c : c + 1'b1;
  endfunction

  // Per-channel held state
  pd_state_t   state_q [NCH];
  logic [1:0]  pq_q    [NCH];
  logic [LW-1:0] cnt_q [NCH];
  logic [NCH-1:0] pv_q;

  // Stage p0: channel read and next-state evaluation
  logic                     vld_p0;
  logic [IW-1:0]            sel_p0;
  logic                     clr_hit_p0;
  pd_state_t                st_cur_p0;
  pd_state_t                nxt_p0;
  logic                     pv_cur_p0;
  logic [1:0]               pq_cur_p0;
  logic [1:0]               quad_p0;
  logic [LW-1:0]            cnt_cur_p0;
  logic signed [DATA_W-1:0] ang_nxt_p0;
  logic [DATA_W-1:0]        mag_p0;
  logic                     in_win_p0;
  logic [LW-1:0]            cnt_nxt_p0;
  logic                     lock_nxt_p0;
  logic                     trans_pn_p0;
  logic                     trans_np_p0;
  logic                     unused_trans;

  // A clear coincident with a strobe makes the sample look like the first
  // one after reset: linear state and no previous quadrant.
  always_comb begin
    vld_p0     = strobe_in && ({1'b0, chan_in} < NCH_C);
    sel_p0     = chan_in[IW-1:0];
    clr_hit_p0 = chan_clr[sel_p0];
    st_cur_p0  = clr_hit_p0 ? PD_LINEAR : state_q[sel_p0];
    pv_cur_p0  = pv_q[sel_p0] & ~clr_hit_p0;
    pq_cur_p0  = pq_q[sel_p0];
    cnt_cur_p0 = cnt_q[sel_p0];
    quad_p0    = ang_in[DATA_W-1 -: 2];
  end

  pdetect_mc_fsm u_fsm (
    .state      (st_cur_p0),
    .prev_quad  (pq_cur_p0),
    .prev_valid (pv_cur_p0),
    .quad       (quad_p0),
    .next       (nxt_p0),
    .trans_pn   (trans_pn_p0),
    .trans_np   (trans_np_p0)
  );

  // Wrap flags are kept on the FSM interface for debug; only next is used.
  assign unused_trans = trans_pn_p0 ^ trans_np_p0;

  always_comb begin
    ang_nxt_p0  = err_out(nxt_p0, ang_in, clip_mag);
    mag_p0      = abs_mag(ang_in);
    in_win_p0   = (nxt_p0 == PD_LINEAR) && (mag_p0 <= {1'b0, lock_thr});
    cnt_nxt_p0  = in_win_p0 ? sat_inc(cnt_cur_p0) : '0;
    lock_nxt_p0 = in_win_p0 && (cnt_nxt_p0 >= lock_len);
  end

  // Stage p1: registered outputs and channel state write-back
  logic                     vld_p1;
  logic signed [DATA_W-1:0] ang_p1;
  logic [CW-1:0]            chan_p1;
  pd_state_t                state_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      ang_p1   <= '0;
      chan_p1  <= '0;
      state_p1 <= PD_LINEAR;
      locked   <= '0;
      pv_q     <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= PD_LINEAR;
        cnt_q[i]   <= '0;
      end
    end else begin
      vld_p1 <= vld_p0;
      for (int i = 0; i < NCH; i++) begin
        if (chan_clr[i]) begin
          state_q[i] <= PD_LINEAR;
          pv_q[i]    <= 1'b0;
          cnt_q[i]   <= '0;
          locked[i]  <= 1'b0;
        end
      end
      if (vld_p0) begin
        ang_p1   <= ang_nxt_p0;
        chan_p1  <= chan_in;
        state_p1 <= nxt_p0;
        if (!clr_hit_p0) begin
          state_q[sel_p0] <= nxt_p0;
          pq_q[sel_p0]    <= quad_p0;
          pv_q[sel_p0]    <= 1'b1;
          cnt_q[sel_p0]   <= cnt_nxt_p0;
          locked[sel_p0]  <= lock_nxt_p0;
        end
      end
    end
  end

  assign ang_out    = ang_p1;
  assign chan_out   = chan_p1;
  assign strobe_out = vld_p1;
  assign state_out  = state_p1;

endmodule

// File: tb/tb_pdetect_mc.sv
// Scoreboard bench for pdetect_mc. The reference model tracks each channel as
// a signed integer phase history with a mode of 0 / +1 / -1 (linear, clipped
// positive, clipped negative) and an in-window run length.
module tb_pdetect_mc;

  localparam int W   = 17;
  localparam int NCH = 4;
  localparam int CW  = 3;
  localparam int LW  = 12;
  localparam int QTR = 1 << (W-2);

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic signed [W-1:0] ang_in = '0;
  logic [CW-1:0]       chan_in = '0;
  logic                strobe_in = 1'b0;
  logic [NCH-1:0]      chan_clr = '0;
  logic [W-2:0]        clip_mag = 16'hFFFF;
  logic [W-2:0]        lock_thr = 16'd256;
  logic [LW-1:0]       lock_len = 12'd8;
  logic signed [W-1:0] ang_out;
  logic [CW-1:0]       chan_out;
  logic                strobe_out;
  logic [1:0]          state_out;
  logic [NCH-1:0]      locked;

  pdetect_mc #(.DATA_W(W), .NCH(NCH), .CW(CW), .LW(LW)) dut (
    .clk        (clk),
    .reset      (reset),
    .ang_in     (ang_in),
    .chan_in    (chan_in),
    .strobe_in  (strobe_in),
    .chan_clr   (chan_clr),
    .clip_mag   (clip_mag),
    .lock_thr   (lock_thr),
    .lock_len   (lock_len),
    .ang_out    (ang_out),
    .chan_out   (chan_out),
    .strobe_out (strobe_out),
    .state_out  (state_out),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             due;
    logic [W-1:0]   ang;
    int             ch;
    int             st;
    logic [NCH-1:0] lk;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  bit   rst_d = 1'b0;
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   passes = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= reset;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  int             m_mode [NCH];
  bit             m_has  [NCH];
  int             m_last [NCH];
  int             m_run  [NCH];
  logic [NCH-1:0] m_lk;

  function automatic int sx(input logic [W-1:0] v);
    return v[W-1] ? int'(v) - (1 << W) : int'(v);
  endfunction

  task automatic model_clear(input int i);
    m_mode[i] = 0;
    m_has[i]  = 1'b0;
    m_last[i] = 0;
    m_run[i]  = 0;
    m_lk[i]   = 1'b0;
  endtask

  task automatic model_strobe(input int ch, input logic [W-1:0] v, input int due);
    int   a, out, mag;
    bit   up, dn, inwin;
    exp_t e;
    a  = sx(v);
    up = m_has[ch] && (m_last[ch] >= QTR) && (a < -QTR);
    dn = m_has[ch] && (m_last[ch] < -QTR) && (a >= QTR);
    if (m_mode[ch] == 0) begin
      if (up)      m_mode[ch] = 1;
      else if (dn) m_mode[ch] = -1;
    end else if (m_mode[ch] == 1 && dn) m_mode[ch] = 0;
    else if (m_mode[ch] == -1 && up)    m_mode[ch] = 0;
    out   = (m_mode[ch] == 0) ? a : m_mode[ch] * int'(clip_mag);
    mag   = (a < 0) ? -a : a;
    inwin = (m_mode[ch] == 0) && (mag <= int'(lock_thr));
    m_run[ch] = inwin ? m_run[ch] + 1 : 0;
    m_lk[ch]  = inwin && (m_run[ch] >= int'(lock_len));
    m_has[ch]  = 1'b1;
    m_last[ch] = a;
    e.due = due;
    e.ang = out[W-1:0];
    e.ch  = ch;
    e.st  = (m_mode[ch] == 0) ? 0 : ((m_mode[ch] > 0) ? 2 : 3);
    e.lk  = m_lk;
    sb.push_back(e);
  endtask

  // One clock of stimulus; the model consumes the same cycle's inputs.
  task automatic drive(input int ch, input logic [W-1:0] v, input bit stb = 1'b1,
                       input logic [NCH-1:0] clr = '0, input bit rst = 1'b0);
    exp_t e;
    chan_in   = CW'(ch);
    ang_in    = v;
    strobe_in = stb;
    chan_clr  = clr;
    reset     = rst;
    if (rst) begin
      for (int i = 0; i < NCH; i++) model_clear(i);
    end else begin
      for (int i = 0; i < NCH; i++) if (clr[i]) model_clear(i);
      if (stb && ch < NCH) begin
        if (clr[ch]) begin
          e.due = cyc + 1;
          e.ang = v;
          e.ch  = ch;
          e.st  = 0;
          e.lk  = m_lk;
          sb.push_back(e);
        end else begin
          model_strobe(ch, v, cyc + 1);
        end
      end
    end
    @(posedge clk);
    #1;
    strobe_in = 1'b0;
    chan_clr  = '0;
    reset     = 1'b0;
  endtask

  // ---------------- monitor ----------------
  exp_t           me;
  logic [W-1:0]   h_ang = '0;
  logic [CW-1:0]  h_ch = '0;
  logic [1:0]     h_st = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_d) begin
        chk("rst_strobe_out", {31'd0, strobe_out}, 32'd0);
        chk("rst_ang_out", {15'd0, ang_out}, 32'd0);
        chk("rst_chan_out", {29'd0, chan_out}, 32'd0);
        chk("rst_state_out", {30'd0, state_out}, 32'd0);
        chk("rst_locked", {28'd0, locked}, 32'd0);
        h_ang = '0;
        h_ch  = '0;
        h_st  = '0;
      end else if (strobe_out) begin
        if (sb.size() == 0) begin
          chk("spurious_strobe_out", 32'd1, 32'd0);
        end else begin
          me = sb.pop_front();
          chk("latency", cyc, me.due);
          chk("ang_out", {15'd0, ang_out}, {15'd0, me.ang});
          chk("chan_out", {29'd0, chan_out}, me.ch);
          chk("state_out", {30'd0, state_out}, me.st);
          chk("locked", {28'd0, locked}, {28'd0, me.lk});
          h_ang = me.ang;
          h_ch  = CW'(me.ch);
          h_st  = 2'(me.st);
        end
      end else begin
        chk("hold_ang_out", {15'd0, ang_out}, {15'd0, h_ang});
        chk("hold_chan_out", {29'd0, chan_out}, {29'd0, h_ch});
        chk("hold_state_out", {30'd0, state_out}, {30'd0, h_st});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0]   a;
    logic [NCH-1:0] clr;
    int             sel, ch;
    bit             stb, rst;

    drive(0, '0, 1'b0, '0, 1'b1);
    mon_en = 1'b1;
    drive(0, '0, 1'b0, '0, 1'b1);

    // Positive ramp on ch0 into CLIP_P
    a = '0;
    for (int k = 0; k < 7; k++) begin
      drive(0, a);
      a = a + 17'h03000;
    end
    // Negative ramp on ch1 interleaved with ch0 held in CLIP_P
    a = '0;
    for (int k = 0; k < 8; k++) begin
      drive(1, a);
      drive(0, 17'h13000);
      a = a - 17'h03000;
    end
    drive(0, 17'h0C000);
    drive(1, 17'h12000);

    // First sample after reset is never a transition
    drive(0, '0, 1'b0, '0, 1'b1);
    drive(3, 17'h10000);

    // Lock on ch2
    for (int k = 0; k < 8; k++) drive(2, 17'd100);
    drive(2, 17'd300);
    drive(2, 17'd100);
    drive(2, 17'h10000);
    lock_thr = 16'hFFFF;
    drive(2, 17'h10000);
    drive(2, 17'h0FFFF);
    lock_thr = 16'd256;

    // Clear coincident with a ch0 strobe in CLIP_P
    drive(0, 17'h08000);
    drive(0, 17'h12000);
    drive(0, 17'h0C000, 1'b1, 4'b0001);
    drive(0, 17'h12000);
    drive(0, 17'h0C000);

    // Zero clip level and zero lock length
    clip_mag = '0;
    lock_len = '0;
    drive(3, 17'h12000);
    drive(3, 17'h0C000);
    drive(1, 17'd5);
    drive(1, 17'd1000);
    clip_mag = 16'hFFFF;
    lock_len = 12'd8;

    // Out-of-range channel, then reset with a strobe in the same cycle
    drive(5, 17'h00123);
    drive(1, 17'h00456, 1'b1, '0, 1'b1);
    drive(0, '0, 1'b0);
    drive(0, '0, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      sel = $urandom_range(0, 3);
      ch  = ($urandom_range(0, 9) < 9) ? $urandom_range(0, 3) : $urandom_range(4, 7);
      case (sel)
        0:       a = W'($urandom);
        1:       a = W'(int'($urandom_range(0, 600)) - 300);
        2:       a = ($urandom_range(0, 1) != 0) ? W'(32'h08000 + $urandom_range(0, 32'h7FFF))
                                                 : W'(32'h10000 + $urandom_range(0, 32'h7FFF));
        default: a = ($urandom_range(0, 1) != 0) ? 17'h10000 : 17'h0FFFF;
      endcase
      clr = ($urandom_range(0, 15) == 0) ? NCH'(1 << $urandom_range(0, NCH-1)) : '0;
      rst = ($urandom_range(0, 199) == 0);
      stb = ($urandom_range(0, 3) != 0);
      drive(ch, a, stb, clr, rst);
      if (k % 150 == 149) begin
        clip_mag = 16'($urandom);
        lock_len = 12'($urandom_range(0, 6));
        lock_thr = 16'($urandom_range(0, 400));
      end
    end

    drive(0, '0, 1'b0);
    drive(0, '0, 1'b0);
    drive(0, '0, 1'b0);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
